vend_multi: RTL and testbench
=============================

# vend_multi

Parametrised multi-item vending controller, the next generation of the single-product drink FSM. It accumulates half-unit coin credit and latches an item selection, then auto-dispenses when credit covers that item's price. Change and cancel refunds are returned as a serial stream of coin pulses. It sits between the coin/keypad front end and the dispenser and change-hopper drivers.

## Interface
- N_ITEMS, 4: number of selectable items.
- SEL_W, 2: selection width; requires 2^SEL_W ≥ N_ITEMS.
- CREDIT_W, 5: credit register width, counted in half-units (1 unit = 0.5).
- MAX_CREDIT, 16: highest credit accepted; requires MAX_CREDIT ≤ 2^CREDIT_W − 1.
- PRICE_LIST, {5'd6,5'd5,5'd4,5'd3}: packed prices, N_ITEMS×CREDIT_W bits; item i is at [i*CREDIT_W +: CREDIT_W]; every price is ≥ 1.
- TIMEOUT, 64: inactivity refund delay in cycles; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; 0 at a posedge resets the block.
- coin  in  2  00 none, 01 = 1 unit, 10 = 2 units, 11 = cancel.
- sel  in  SEL_W  item index.
- sel_valid  in  1  1 = latch sel this edge.
- drink  out  1  one-cycle dispense pulse.
- item  out  SEL_W  index dispensed; valid while drink=1 and held afterwards.
- back  out  2  coin returned this cycle: 01 = 1 unit, 10 = 2 units, 00 none.
- credit  out  CREDIT_W  current credit.
- busy  out  1  1 while in CHANGE.

## Operation
- States: IDLE and CHANGE. All outputs are registered.
- Reset: state IDLE; credit, drink, item, back, busy, internal sel_hold, sel_ok and timer all 0.
- IDLE, evaluated in priority order on registered values:
  - Vend: sel_ok=1 and credit ≥ price(sel_hold).
    - drink←1, item←sel_hold, credit←credit−price, sel_ok←0.
    - Next state is CHANGE if the remainder is > 0, otherwise IDLE.
    - A coin 01/10 arriving in the vend cycle is bounced (back←coin). Cancel and sel_valid in the vend cycle are ignored.
  - Cancel (coin=11): if credit > 0, go to CHANGE and clear sel_ok; if credit = 0, no effect.
  - Coin 01/10: if credit+value ≤ MAX_CREDIT, credit += value; otherwise credit is unchanged and back←coin for one cycle (bounce).
  - sel_valid: if sel < N_ITEMS, sel_hold←sel and sel_ok←1; otherwise ignored. It may coincide with a coin on the same edge and both take effect.
- CHANGE, each edge:
  - credit ≥ 2: back←10, credit −= 2.
  - credit = 1: back←01, credit←0.
  - Go to IDLE on the edge where credit reaches 0.
  - coin and sel_valid are ignored: no credit change and no bounce.
- In all other cycles, drink←0 and back←00.

## Timing
- Credit updates on the edge that samples the coin.
- Vend happens on the edge after credit reaches the price, so drink is high for the cycle after the vend edge.
- The first change coin appears one cycle after drink.
- Change takes ceil(remainder/2) cycles. busy=1 for exactly those cycles.
- Bounce: back=coin during the cycle after the sampling edge.
- Reset low mid-CHANGE aborts immediately: remaining credit is discarded and back=00 the next cycle.
- Credit never exceeds MAX_CREDIT and never underflows.

## Configuration
- VEND_TIMEOUT_EN defined:
  - The timer counts IDLE edges with credit > 0 and no accepted coin, cancel or sel_valid.
  - Any such activity, or credit = 0, clears the timer.
  - On the edge where timer = TIMEOUT−1, the block enters CHANGE, clears sel_ok and clears the timer.
  - A vend on that same edge takes priority.
- VEND_TIMEOUT_EN undefined: no timer logic. Credit is held indefinitely and TIMEOUT is unused.

## Test plan
- Reset held low while coin=10 and sel_valid=1 → after release: credit=0, drink=0, back=00, busy=0.
- sel_valid with sel=0 (price 3), then coin 01 then 10 on consecutive edges → credit=3; drink=1 with item=0 for one cycle on the next edge; credit=0; back stays 00.
- sel=3 (price 6), four coins of 10 → credit=8; vend leaves credit=2; back=10 for one cycle with busy=1; then IDLE with credit=0.
- credit=15, coin=10 → back=10 for one cycle, credit stays 15. A following coin=01 → credit=16.
- credit=5, no selection, coin=11 → back sequence 10, 10, 01 on successive cycles; busy=1 for 3 cycles; coins inserted meanwhile leave credit at 0.
- With VEND_TIMEOUT_EN and TIMEOUT=8: one coin 01 then idle → CHANGE entered on the 8th idle edge and back=01 on the next edge. Without the macro: credit=1 after 100 cycles.

Source files
------------

// File: rtl/vend_multi.sv
// rtl/vend_multi.sv - multi-item vending controller with serial change return
// Optional inactivity refund timer enabled by defining VEND_TIMEOUT_EN.
module vend_multi #(
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 16,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {5'd6, 5'd5, 5'd4, 5'd3},
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    output logic                drink,
    output logic [SEL_W-1:0]    item,
    output logic [1:0]          back,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_CHANGE = 1'b1;

    logic                state;
    logic [SEL_W-1:0]    sel_hold;
    logic                sel_ok;
    logic [CREDIT_W-1:0] prices [N_ITEMS];
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                is_coin;
    logic                is_cancel;
    logic                fits;
    logic                sel_in_range;
    logic                can_vend;

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
        assign prices[i] = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end

    always_comb begin
        is_coin      = (coin == 2'b01) || (coin == 2'b10);
        is_cancel    = (coin == 2'b11);
        coin_val     = (coin == 2'b01) ? (CREDIT_W+1)'(1) :
                       (coin == 2'b10) ? (CREDIT_W+1)'(2) : '0;
        sum          = {1'b0, credit} + coin_val;
        fits         = sum <= (CREDIT_W+1)'(MAX_CREDIT);
        sel_in_range = 32'(sel) < N_ITEMS;
        price        = prices[sel_hold];
        can_vend     = sel_ok && (credit >= price);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;
    logic             activity;
    assign activity = (is_coin && fits) || (sel_valid && sel_in_range);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            credit   <= '0;
            drink    <= 1'b0;
            item     <= '0;
            back     <= 2'b00;
            busy     <= 1'b0;
            sel_hold <= '0;
            sel_ok   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            timer    <= '0;
`endif
        end else begin
            drink <= 1'b0;
            back  <= 2'b00;
            // busy trails the state so it lines up with the change coins on back
            busy  <= (state == S_CHANGE);
            case (state)
                S_IDLE: begin
                    if (can_vend) begin
                        drink  <= 1'b1;
                        item   <= sel_hold;
                        credit <= credit - price;
                        sel_ok <= 1'b0;
                        if (credit != price) state <= S_CHANGE;
                        if (is_coin) back <= coin;
`ifdef VEND_TIMEOUT_EN
                        timer  <= '0;
`endif
                    end else if (is_cancel && credit != '0) begin
                        state  <= S_CHANGE;
                        sel_ok <= 1'b0;
`ifdef VEND_TIMEOUT_EN
                        timer  <= '0;
`endif
                    end else begin
                        if (is_coin) begin
                            if (fits) credit <= sum[CREDIT_W-1:0];
                            else      back   <= coin;
                        end
                        if (sel_valid && sel_in_range) begin
                            sel_hold <= sel;
                            sel_ok   <= 1'b1;
                        end
`ifdef VEND_TIMEOUT_EN
                        if (credit == '0 || activity) begin
                            timer <= '0;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            state  <= S_CHANGE;
                            sel_ok <= 1'b0;
                            timer  <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    if (credit >= CREDIT_W'(2)) begin
                        back   <= 2'b10;
                        credit <= credit - CREDIT_W'(2);
                        if (credit == CREDIT_W'(2)) state <= S_IDLE;
                    end else if (credit == CREDIT_W'(1)) begin
                        back   <= 2'b01;
                        credit <= '0;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
`ifdef VEND_TIMEOUT_EN
                    timer <= '0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_multi.sv
// tb/tb_vend_multi.sv - directed self-checking bench for vend_multi
module tb_vend_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       sel_valid;
    logic       drink;
    logic [1:0] item;
    logic [1:0] back;
    logic [4:0] credit;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    vend_multi #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .coin(coin), .sel(sel), .sel_valid(sel_valid),
        .drink(drink), .item(item), .back(back), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s);
        coin = c; sel_valid = sv; sel = s;
        tick();
        coin = 2'b00; sel_valid = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [4:0] cr, input logic dr,
                        input logic [1:0] bk, input logic bs);
        check({tag, "_credit"}, 32'(credit), 32'(cr));
        check({tag, "_drink"},  32'(drink),  32'(dr));
        check({tag, "_back"},   32'(back),   32'(bk));
        check({tag, "_busy"},   32'(busy),   32'(bs));
    endtask

    initial begin
        reset = 1'b0; coin = 2'b10; sel = 2'd0; sel_valid = 1'b1;
        tick(); tick(); tick();
        outs("rst_hold", 5'd0, 1'b0, 2'b00, 1'b0);
        reset = 1'b1; coin = 2'b00; sel_valid = 1'b0;
        tick();
        outs("rst_rel", 5'd0, 1'b0, 2'b00, 1'b0);

        // item 0, price 3: exact payment
        step(2'b00, 1'b1, 2'd0);
        step(2'b01, 1'b0, 2'd0);
        check("exact_c1", 32'(credit), 32'd1);
        step(2'b10, 1'b0, 2'd0);
        outs("exact_c3", 5'd3, 1'b0, 2'b00, 1'b0);
        tick();
        outs("exact_vend", 5'd0, 1'b1, 2'b00, 1'b0);
        check("exact_item", 32'(item), 32'd0);
        tick();
        outs("exact_after", 5'd0, 1'b0, 2'b00, 1'b0);
        check("exact_item_hold", 32'(item), 32'd0);

        // item 3, price 6: credit 8, change of one 2-unit coin
        repeat (4) step(2'b10, 1'b0, 2'd0);
        check("c8", 32'(credit), 32'd8);
        step(2'b00, 1'b1, 2'd3);
        check("c8_sel", 32'(credit), 32'd8);
        tick();
        outs("vend3", 5'd2, 1'b1, 2'b00, 1'b0);
        check("vend3_item", 32'(item), 32'd3);
        tick();
        outs("vend3_chg", 5'd0, 1'b0, 2'b10, 1'b1);
        tick();
        outs("vend3_done", 5'd0, 1'b0, 2'b00, 1'b0);

        // overflow bounce at 15, then fill to 16
        repeat (7) step(2'b10, 1'b0, 2'd0);
        step(2'b01, 1'b0, 2'd0);
        check("c15", 32'(credit), 32'd15);
        step(2'b10, 1'b0, 2'd0);
        outs("bounce", 5'd15, 1'b0, 2'b10, 1'b0);
        step(2'b01, 1'b0, 2'd0);
        outs("c16", 5'd16, 1'b0, 2'b00, 1'b0);
        step(2'b11, 1'b0, 2'd0);
        check("cancel16_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("cancel16_back", 32'(back), 32'(2'b10));
        end
        tick();
        outs("cancel16_done", 5'd0, 1'b0, 2'b00, 1'b0);

        // cancel with credit 5, coins during change are ignored
        step(2'b10, 1'b0, 2'd0);
        step(2'b10, 1'b0, 2'd0);
        step(2'b01, 1'b0, 2'd0);
        check("c5", 32'(credit), 32'd5);
        step(2'b11, 1'b0, 2'd0);
        outs("cancel5", 5'd5, 1'b0, 2'b00, 1'b0);
        step(2'b10, 1'b0, 2'd0);
        outs("chg1", 5'd3, 1'b0, 2'b10, 1'b1);
        step(2'b01, 1'b1, 2'd1);
        outs("chg2", 5'd1, 1'b0, 2'b10, 1'b1);
        step(2'b10, 1'b0, 2'd0);
        outs("chg3", 5'd0, 1'b0, 2'b01, 1'b1);
        tick();
        outs("chg_done", 5'd0, 1'b0, 2'b00, 1'b0);

        // coin arriving on the vend edge is bounced
        step(2'b00, 1'b1, 2'd0);
        step(2'b10, 1'b0, 2'd0);
        step(2'b10, 1'b0, 2'd0);
        check("vb_c4", 32'(credit), 32'd4);
        step(2'b01, 1'b0, 2'd0);
        outs("vb_vend", 5'd1, 1'b1, 2'b01, 1'b0);
        tick();
        outs("vb_chg", 5'd0, 1'b0, 2'b01, 1'b1);
        tick();

        // reset mid-change discards credit
        step(2'b10, 1'b0, 2'd0);
        step(2'b10, 1'b0, 2'd0);
        step(2'b10, 1'b0, 2'd0);
        step(2'b11, 1'b0, 2'd0);
        tick();
        outs("abort_chg", 5'd4, 1'b0, 2'b10, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        outs("abort", 5'd0, 1'b0, 2'b00, 1'b0);
        tick();
        outs("abort_after", 5'd0, 1'b0, 2'b00, 1'b0);

        // inactivity refund
        step(2'b01, 1'b0, 2'd0);
`ifdef VEND_TIMEOUT_EN
        repeat (8) begin
            tick();
            check("to_wait_back", 32'(back), 32'd0);
            check("to_wait_busy", 32'(busy), 32'd0);
        end
        check("to_wait_credit", 32'(credit), 32'd1);
        tick();
        outs("to_refund", 5'd0, 1'b0, 2'b01, 1'b1);
`else
        repeat (100) tick();
        outs("no_timeout", 5'd1, 1'b0, 2'b00, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
